// File: rtl/count_seq_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | count_seq_pkg: mode/state encodings and per-mode counter seeds.     |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package count_seq_pkg;

  typedef enum logic [1:0] {
    MODE_RING    = 2'b00,
    MODE_JOHNSON = 2'b01,
    MODE_BINARY  = 2'b10,
    MODE_DECADE  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [3:0] SEED_RING    = 4'b1000;
  localparam logic [3:0] SEED_JOHNSON = 4'b0000;
  localparam logic [3:0] SEED_BINARY  = 4'b0000;
  localparam logic [3:0] SEED_DECADE  = 4'b0000;

  function automatic logic [3:0] mode_seed(input logic [1:0] mode);
    logic [3:0] seed;
    case (mode)
      MODE_RING:    seed = SEED_RING;
      MODE_JOHNSON: seed = SEED_JOHNSON;
      MODE_BINARY:  seed = SEED_BINARY;
      default:      seed = SEED_DECADE;
    endcase
    return seed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_core.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | count_core: 4-bit counter with ring/johnson/binary/decade stepping. |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module count_core
  import count_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic       step,
  input  logic [3:0] seed,
  output logic [3:0] q
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      case (mode)
        MODE_RING:    q_d = {q_q[0], q_q[3:1]};
        MODE_JOHNSON: q_d = {~q_q[0], q_q[3:1]};
        MODE_BINARY:  q_d = q_q + 4'd1;
        default:      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | count_seq_ctrl: round-robin arbiter + run FSM over a shared counter.|
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       mode0,
  input  logic [1:0]       mode1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [3:0]       cnt_q,
  output logic             done,
  output logic             done_id
);

  localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             win_q, win_d;
  logic             rr_q, rr_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             core_load, core_step, pick;

  // Requester 1 wins when alone, or when both ask and the pointer favours it.
  assign pick = req[1] & (~req[0] | rr_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    win_d     = win_q;
    rr_d      = rr_q;
    mode_d    = mode_q;
    len_d     = len_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          rr_d    = ~pick;
          mode_d  = pick ? mode1 : mode0;
          len_d   = pick ? len1 : len0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!req[win_q]) begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else begin
          core_load = 1'b1;
          rem_d     = (len_q == '0) ? REM_FULL : {1'b0, len_q};
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req[win_q]) begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          rem_d     = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = ST_DONE;
        end
      end
      default: begin
        // Pulse is registered on the way out, so it lines up with IDLE.
        done_d    = 1'b1;
        done_id_d = win_q;
        gnt_d     = 2'b00;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      win_q     <= 1'b0;
      rr_q      <= 1'b0;
      mode_q    <= 2'b00;
      len_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  count_core u_core (
    .clk   (clk),
    .reset (reset),
    .mode  (mode_q),
    .load  (core_load),
    .step  (core_step),
    .seed  (mode_seed(mode_q)),
    .q     (cnt_q)
  );

  assign gnt     = gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_count_seq_ctrl: scoreboard bench with a sequence-level model.    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] mode0, mode1;
  logic [3:0] len0, len1;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] cnt_q;
  logic       done;
  logic       done_id;

  count_seq_ctrl #(.LEN_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .mode0   (mode0),
    .mode1   (mode1),
    .len0    (len0),
    .len1    (len1),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_q   (cnt_q),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rr_model = 0;

  // Expected run records: requester, number of cnt values seen, ending kind
  // (0 completes with done, 1 abandoned, 2 cut short by reset).
  int         q_id[$];
  int         q_n[$];
  int         q_kind[$];
  logic [3:0] q_seq[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Counter value k steps after the seed, straight from the mode definitions.
  function automatic logic [3:0] exp_val(input int mode, input int k);
    int m;
    case (mode)
      0: return 4'(8 >> (k % 4));
      1: begin
        m = k % 8;
        if (m <= 4) return 4'((15 << (4 - m)) & 15);
        else        return 4'(15 >> (m - 4));
      end
      2: return 4'(k % 16);
      default: return 4'(k % 10);
    endcase
  endfunction

  task automatic push_exp(input int id, input int mode, input int nvals, input int kind);
    q_id.push_back(id);
    q_n.push_back(nvals);
    q_kind.push_back(kind);
    for (int k = 0; k < nvals; k++) q_seq.push_back(exp_val(mode, k));
  endtask

  task automatic wait_gnt(input int id, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (gnt[id]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("gnt_timeout", 8'h0, 8'h1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 8'h0, 8'h1);
  endtask

  task automatic set_inputs(input int id, input int mode, input int len);
    if (id == 0) begin mode0 = 2'(mode); len0 = 4'(len); end
    else         begin mode1 = 2'(mode); len1 = 4'(len); end
  endtask

  // drop_d > 0 releases req on the drop_d-th negedge after the grant is seen.
  task automatic run_one(input int id, input int mode, input int len, input int drop_d);
    int steps = (len == 0) ? 16 : len;
    bit ok;
    if (drop_d > 0) push_exp(id, mode, drop_d, 1);
    else            push_exp(id, mode, steps + 1, 0);
    rr_model = 1 - id;
    @(negedge clk);
    set_inputs(id, mode, len);
    req[id] = 1'b1;
    wait_gnt(id, ok);
    if (ok) begin
      set_inputs(id, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if (drop_d > 0) begin
        repeat (drop_d) @(negedge clk);
        req[id] = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        wait_done();
      end
    end
    req[id] = 1'b0;
  endtask

  task automatic run_pair(input int m0, input int l0, input int m1, input int l1);
    int first  = rr_model;
    int second = 1 - rr_model;
    push_exp(first,  (first == 0) ? m0 : m1, ((first == 0 ? l0 : l1) == 0 ? 16 : (first == 0 ? l0 : l1)) + 1, 0);
    push_exp(second, (second == 0) ? m0 : m1, ((second == 0 ? l0 : l1) == 0 ? 16 : (second == 0 ? l0 : l1)) + 1, 0);
    rr_model = first;
    @(negedge clk);
    set_inputs(0, m0, l0);
    set_inputs(1, m1, l1);
    req = 2'b11;
    wait_done();
    req[first] = 1'b0;
    wait_done();
    req[second] = 1'b0;
  endtask

  task automatic reset_mid(input int id, input int mode, input int len);
    bit ok;
    push_exp(id, mode, 0, 2);
    @(negedge clk);
    set_inputs(id, mode, len);
    req[id] = 1'b1;
    wait_gnt(id, ok);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_gnt",     8'(gnt),     8'h0);
    chk("mid_rst_busy",    8'(busy),    8'h0);
    chk("mid_rst_cnt",     8'(cnt_q),   8'h0);
    chk("mid_rst_done",    8'(done),    8'h0);
    chk("mid_rst_done_id", 8'(done_id), 8'h0);
    req = 2'b00;
    rr_model = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: each grant pops one record and follows the run to its end.
  initial begin
    int         trk = 0, i = 0, cur_id = 0, cur_n = 0, cur_kind = 0;
    logic [3:0] cur_seq [0:16];
    logic [1:0] prev_gnt = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        trk = 0;
        prev_gnt = 2'b00;
        continue;
      end
      if (trk != 0) begin
        i++;
        if (i <= cur_n) begin
          chk("cnt_seq", 8'(cnt_q), 8'(cur_seq[i-1]));
          chk("busy_run", 8'(busy), 8'h1);
          chk("done_early", 8'(done), 8'h0);
        end else begin
          chk("end_gnt",  8'(gnt),   8'h0);
          chk("end_busy", 8'(busy),  8'h0);
          chk("end_cnt",  8'(cnt_q), 8'(cur_seq[cur_n-1]));
          if (cur_kind == 0) begin
            chk("done_pulse", 8'(done),    8'h1);
            chk("done_id",    8'(done_id), 8'(cur_id));
          end else begin
            chk("no_done_abandon", 8'(done), 8'h0);
          end
          trk = 0;
        end
      end else if (prev_gnt == 2'b00 && gnt != 2'b00) begin
        if (q_id.size() == 0) begin
          chk("unexpected_grant", 8'(gnt), 8'h0);
        end else begin
          cur_id   = q_id.pop_front();
          cur_n    = q_n.pop_front();
          cur_kind = q_kind.pop_front();
          for (int k = 0; k < cur_n; k++) cur_seq[k] = q_seq.pop_front();
          chk("gnt_onehot", 8'(gnt), (cur_id == 1) ? 8'h2 : 8'h1);
          i   = 0;
          trk = (cur_kind == 2) ? 0 : 1;
        end
      end else if (done) begin
        chk("spurious_done", 8'(done), 8'h0);
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    reset = 1'b1;
    req   = 2'b00;
    mode0 = 2'b00; mode1 = 2'b00;
    len0  = 4'd0;  len1  = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",     8'(gnt),     8'h0);
    chk("rst_busy",    8'(busy),    8'h0);
    chk("rst_cnt",     8'(cnt_q),   8'h0);
    chk("rst_done",    8'(done),    8'h0);
    chk("rst_done_id", 8'(done_id), 8'h0);
    reset = 1'b0;

    run_pair(0, 4, 1, 8);
    run_pair(3, 5, 2, 3);
    run_one(0, 0, 4, 0);
    run_one(1, 1, 8, 0);
    run_one(0, 3, 12, 0);
    run_one(0, 2, 0, 0);
    run_one(0, 0, 8, 3);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        run_pair(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      end else begin
        int id   = int'($urandom_range(0, 1));
        int mode = int'($urandom_range(0, 3));
        int len  = int'($urandom_range(0, 15));
        steps = (len == 0) ? 16 : len;
        if ($urandom_range(0, 4) == 0) run_one(id, mode, len, int'($urandom_range(1, steps)));
        else                           run_one(id, mode, len, 0);
      end
    end

    run_one(1, 1, 5, 0);
    reset_mid(0, 2, 10);
    run_pair(1, 3, 0, 2);
    run_one(0, 3, 7, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", 8'(q_id.size()), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
